// File: rtl/id_stage.sv
// Instruction-decode stage: field extraction, control decode, 32x32 register file
// with WB write-through bypass, load-use hazard detection and the ID/EX register.
module id_stage #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            n_rst_i,
    input  logic [31:0]     IFID_pc_i,
    input  logic [31:0]     IFID_ir_i,
    input  logic            MEM_do_branch_i,
    input  logic            WB_reg_write_i,
    input  logic [4:0]      WB_rd_addr_i,
    input  logic [XLEN-1:0] WB_rd_data_i,
    output logic            ID_stall_o,
    output logic [31:0]     IDEX_pc_o,
    output logic [XLEN-1:0] IDEX_rs_data_o,
    output logic [XLEN-1:0] IDEX_rt_data_o,
    output logic [XLEN-1:0] IDEX_imm_o,
    output logic [4:0]      IDEX_rs_addr_o,
    output logic [4:0]      IDEX_rt_addr_o,
    output logic [4:0]      IDEX_rd_addr_o,
    output logic [5:0]      IDEX_opcode_o,
    output logic [5:0]      IDEX_funct_o,
    output logic            IDEX_reg_write_o,
    output logic            IDEX_mem_read_o,
    output logic            IDEX_mem_write_o,
    output logic            IDEX_branch_o
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef struct packed {
        logic [31:0]     pc;
        logic [XLEN-1:0] rs_data;
        logic [XLEN-1:0] rt_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs_addr;
        logic [4:0]      rt_addr;
        logic [4:0]      rd_addr;
        logic [5:0]      opcode;
        logic [5:0]      funct;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
    } idex_t;

    logic [NREG-1:0][XLEN-1:0] rf_q;
    idex_t                     idex_q, idex_d, dec;

    logic [5:0]      opcode;
    logic [4:0]      rs, rt, rd;
    logic [XLEN-1:0] rs_data, rt_data;
    logic            wb_we, hazard;

    assign opcode = IFID_ir_i[31:26];
    assign rs     = IFID_ir_i[25:21];
    assign rt     = IFID_ir_i[20:16];
    assign rd     = IFID_ir_i[15:11];
    assign wb_we  = WB_reg_write_i && (WB_rd_addr_i != 5'd0);

    // Register 0 never written; bypass makes a same-cycle WB write visible to ID.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs != 5'd0) rs_data = (wb_we && WB_rd_addr_i == rs) ? WB_rd_data_i : rf_q[rs];
        if (rt != 5'd0) rt_data = (wb_we && WB_rd_addr_i == rt) ? WB_rd_data_i : rf_q[rt];
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            rf_q <= '0;
        end else if (wb_we) begin
            rf_q[WB_rd_addr_i] <= WB_rd_data_i;
        end
    end

    always_comb begin
        dec         = '0;
        dec.pc      = IFID_pc_i;
        dec.rs_data = rs_data;
        dec.rt_data = rt_data;
        dec.imm     = {{(XLEN-16){IFID_ir_i[15]}}, IFID_ir_i[15:0]};
        dec.rs_addr = rs;
        dec.rt_addr = rt;
        dec.opcode  = opcode;
        dec.funct   = IFID_ir_i[5:0];
        case (opcode)
            OP_RTYPE: begin dec.reg_write = 1'b1; dec.rd_addr = rd; end
            OP_ADDI:  begin dec.reg_write = 1'b1; dec.rd_addr = rt; end
            OP_LW:    begin dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.rd_addr = rt; end
            OP_SW:    dec.mem_write = 1'b1;
            OP_BEQ:   dec.branch    = 1'b1;
            default:  ;
        endcase
        if (dec.rd_addr == 5'd0) dec.reg_write = 1'b0;
    end

    assign hazard = idex_q.mem_read && (idex_q.rd_addr != 5'd0) &&
                    ((idex_q.rd_addr == rs) || (idex_q.rd_addr == rt));
    assign ID_stall_o = hazard && !MEM_do_branch_i;

    // Branch flush and load-use stall both drop a bubble into EX.
    assign idex_d = (MEM_do_branch_i || ID_stall_o) ? idex_t'('0) : dec;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) idex_q <= '0;
        else          idex_q <= idex_d;
    end

    assign IDEX_pc_o        = idex_q.pc;
    assign IDEX_rs_data_o   = idex_q.rs_data;
    assign IDEX_rt_data_o   = idex_q.rt_data;
    assign IDEX_imm_o       = idex_q.imm;
    assign IDEX_rs_addr_o   = idex_q.rs_addr;
    assign IDEX_rt_addr_o   = idex_q.rt_addr;
    assign IDEX_rd_addr_o   = idex_q.rd_addr;
    assign IDEX_opcode_o    = idex_q.opcode;
    assign IDEX_funct_o     = idex_q.funct;
    assign IDEX_reg_write_o = idex_q.reg_write;
    assign IDEX_mem_read_o  = idex_q.mem_read;
    assign IDEX_mem_write_o = idex_q.mem_write;
    assign IDEX_branch_o    = idex_q.branch;

endmodule
